// File: rtl/multi_strobe_edge_filter_pkg.sv
// Shared types for the multi-channel strobe edge filter.
// Event counters are built only when MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN is defined.
package multi_strobe_edge_filter_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } t_edge_mode;

  localparam int unsigned DEF_NUM_CH             = 4;
  localparam int unsigned DEF_NUM_OF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILTER_LEN         = 4;
  localparam int unsigned DEF_CNT_W              = 16;

  // Width-independent part of the per-channel register set; the sized
  // fields (sync chain, filter count, event count) depend on parameters.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic evt;
  } t_ch_flags;

  localparam t_ch_flags CH_FLAGS_RST = '0;

  function automatic int unsigned fc_width(input int unsigned filter_len);
    return $clog2(filter_len) + 1;
  endfunction

  function automatic logic mode_hit(input t_edge_mode mode, input logic rise,
                                    input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EM_OFF:  hit = 1'b0;
      EM_RISE: hit = rise;
      EM_FALL: hit = fall;
      EM_BOTH: hit = rise | fall;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/multi_strobe_edge_filter_ch_filter.sv
// Single channel: synchroniser, stability filter, edge pulses, mode-selected
// event and (with MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN) a saturating event counter.
module strobe_ch_filter
  import multi_strobe_edge_filter_pkg::*;
#(
  parameter int unsigned NUM_OF_SYNC_STAGES = DEF_NUM_OF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN         = DEF_FILTER_LEN,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             strobe_i,
  input  t_edge_mode       mode_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             event_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned     FC_W    = fc_width(FILTER_LEN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

  typedef struct packed {
    logic [NUM_OF_SYNC_STAGES-1:0] sync;
    logic [FC_W-1:0]               fc;
    t_ch_flags                     flags;
`ifdef MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN
    logic [CNT_W-1:0]              cnt;
`endif
  } t_ch_regs;

  localparam t_ch_regs CH_REGS_RST = '0;

  t_ch_regs regs_q;
  t_ch_regs regs_d;
  logic     sync_s;

  always_comb begin
    regs_d           = regs_q;
    sync_s           = regs_q.sync[NUM_OF_SYNC_STAGES-1];
    regs_d.sync      = {regs_q.sync[NUM_OF_SYNC_STAGES-2:0], strobe_i};
    regs_d.flags.rise = 1'b0;
    regs_d.flags.fall = 1'b0;

    // Level only moves after FILTER_LEN consecutive disagreeing samples;
    // any agreeing sample restarts the qualification.
    if (sync_s == regs_q.flags.level) begin
      regs_d.fc = '0;
    end else if (regs_q.fc == FC_LAST) begin
      regs_d.fc          = '0;
      regs_d.flags.level = sync_s;
      regs_d.flags.rise  = sync_s;
      regs_d.flags.fall  = ~sync_s;
    end else begin
      regs_d.fc = regs_q.fc + FC_W'(1);
    end

    regs_d.flags.evt = mode_hit(mode_i, regs_d.flags.rise, regs_d.flags.fall);

`ifdef MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN
    // A clear coinciding with an event still counts that event.
    if (regs_d.flags.evt) begin
      if (cnt_clr_i) begin
        regs_d.cnt = CNT_W'(1);
      end else if (!(&regs_q.cnt)) begin
        regs_d.cnt = regs_q.cnt + CNT_W'(1);
      end
    end else if (cnt_clr_i) begin
      regs_d.cnt = '0;
    end
`endif
  end

  always_ff @(posedge sys_clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      regs_q <= CH_REGS_RST;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign level_o = regs_q.flags.level;
  assign rise_o  = regs_q.flags.rise;
  assign fall_o  = regs_q.flags.fall;
  assign event_o = regs_q.flags.evt;

`ifdef MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN
  assign cnt_o = regs_q.cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: rtl/multi_strobe_edge_filter.sv
// Multi-channel strobe conditioner: NUM_CH independent filter channels.
// Per-channel event counters are enabled by MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN.
module multi_strobe_edge_filter
  import multi_strobe_edge_filter_pkg::*;
#(
  parameter int unsigned NUM_CH             = DEF_NUM_CH,
  parameter int unsigned NUM_OF_SYNC_STAGES = DEF_NUM_OF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN         = DEF_FILTER_LEN,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic                    sys_clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_CH-1:0]       strobe_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       cnt_clr_i,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH-1:0]       rise_o,
  output logic [NUM_CH-1:0]       fall_o,
  output logic [NUM_CH-1:0]       event_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    strobe_ch_filter #(
      .NUM_OF_SYNC_STAGES (NUM_OF_SYNC_STAGES),
      .FILTER_LEN         (FILTER_LEN),
      .CNT_W              (CNT_W)
    ) u_ch (
      .sys_clk_i (sys_clk_i),
      .rstn_i    (rstn_i),
      .strobe_i  (strobe_i[n]),
      .mode_i    (t_edge_mode'(mode_i[2*n +: 2])),
      .cnt_clr_i (cnt_clr_i[n]),
      .level_o   (level_o[n]),
      .rise_o    (rise_o[n]),
      .fall_o    (fall_o[n]),
      .event_o   (event_o[n]),
      .cnt_o     (cnt_o[CNT_W*n +: CNT_W])
    );
  end

endmodule

// File: doc/multi_strobe_edge_filter.md
Name: multi_strobe_edge_filter

Overview:
- Multi-channel strobe conditioner: per channel, synchronises an asynchronous strobe into the sys_clk_i domain, rejects glitches with a stability filter, and emits single-cycle rise/fall pulses.
- Adds per-channel mode-selected event output and optional saturating event counters.
- Sits between external/async strobes (triggers, handshakes, buttons) and control FSMs or status registers.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- NUM_OF_SYNC_STAGES, 2: synchroniser depth (>=2).
- FILTER_LEN, 4: consecutive cycles the synchronised input must differ from the filtered level before it is accepted (>=1).
- CNT_W, 16: event counter width (>=2), used only with the counter macro.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  reset
- strobe_i  in  NUM_CH  asynchronous strobes, bit n = channel n
- mode_i  in  2*NUM_CH  per-channel event mode, bits [2n+1:2n]
- cnt_clr_i  in  NUM_CH  per-channel synchronous counter clear
- level_o  out  NUM_CH  filtered level
- rise_o  out  NUM_CH  one-cycle rising-edge pulse
- fall_o  out  NUM_CH  one-cycle falling-edge pulse
- event_o  out  NUM_CH  one-cycle mode-selected event pulse
- cnt_o  out  NUM_CH*CNT_W  per-channel event count, bits [CNT_W*(n+1)-1:CNT_W*n]

Behaviour:
- Reset rstn_i, asynchronous, active-high; clock sys_clk_i. All flops rising-edge. Channels are fully independent.
- Reset values: all outputs, synchroniser stages, filter counters, filtered levels and event counters are 0.
- Synchroniser: strobe_i[n] shifts through NUM_OF_SYNC_STAGES flops. s = last stage.
- Filter: per-channel counter fc, width clog2(FILTER_LEN)+1.
  - If s == level: fc <= 0.
  - If s != level and fc < FILTER_LEN-1: fc <= fc+1.
  - If s != level and fc == FILTER_LEN-1: level <= s; fc <= 0.
  - Any return of s to level restarts the count. A pulse shorter than FILTER_LEN cycles at s produces no edge.
- Edge pulses are registered on the same edge that level updates:
  - rise_o <= 1 on a 0->1 level update.
  - fall_o <= 1 on a 1->0 level update.
  - Both outputs are 0 otherwise, so each pulse lasts exactly one cycle.
- Latency: for a strobe_i change sampled at edge 1, s changes at edge N, level, rise_o and fall_o change at edge N+FILTER_LEN. Defaults: edge 6.
- Minimum spacing between consecutive edges on one channel is FILTER_LEN cycles. rise_o and fall_o are never both high on the same channel.
- Mode decode:
  - 00: off.
  - 01: rise.
  - 10: fall.
  - 11: both.
  - event_o is registered with rise_o and fall_o, using mode_i sampled on that same edge. A mode change takes effect on the next edge; no retroactive events.
- Strobe high through reset release: level starts at 0, so a rise is reported at edge N+FILTER_LEN after release.
- Reset mid-filter: fc and level clear immediately; in-progress qualification is discarded.

Optional Feature:
- Macro MULTI_STROBE_EDGE_FILTER_EVENT_CNT_EN.
- Defined:
  - Per-channel CNT_W counter increments on each event_o assertion, saturating at all-ones (no wrap).
  - cnt_clr_i[n] with no event: cnt <= 0.
  - cnt_clr_i[n] coincident with an event: cnt <= 1.
  - cnt_o is the registered counter value; it updates on the edge where event_o is asserted.
- Undefined: no counter flops; cnt_o tied to 0; cnt_clr_i ignored.

Decomposition:
- Package multi_strobe_edge_filter_pkg:
  - enum t_edge_mode {EM_OFF, EM_RISE, EM_FALL, EM_BOTH} (2-bit).
  - Per-channel register struct t_ch_regs: sync, fc, level, rise, fall, event, cnt.
  - Its reset constant.
- One sub-module, strobe_ch_filter: a single channel (sync, filter, edge, event, optional counter). The top generates NUM_CH instances and packs/unpacks the vectors.

Test Plan:
- Defaults; ch0 mode=01; strobe_i[0] 0->1 held -> level_o[0]=1, rise_o[0]=1 and event_o[0]=1 for exactly one cycle at edge 6; fall_o stays 0; other channels stay 0.
- Glitches: strobe_i[1] high for 3 cycles, then 4 cycles, then 5 cycles, with FILTER_LEN=4:
  - The 3-cycle pulse produces no pulse.
  - The 4-cycle pulse produces one rise, then one fall 4 cycles after s returns low.
  - The 5-cycle pulse produces one rise and one fall.
- Mode sweep on ch2 (00, 01, 10, 11) with a 10-cycle high pulse each -> event_o pulse counts are 0, 1, 1, 2; rise_o and fall_o pulse regardless of mode.
- Hold strobe_i all-ones through reset; release -> all channels rise at edge 6. Assert rstn_i mid-qualification -> outputs 0 at once; no stale pulse afterwards.
- With the macro defined and CNT_W=2: 5 events give cnt_o = 1, 2, 3, 3, 3. Clear alone gives 0. Clear coincident with an event gives 1.
- Four channels toggling simultaneously with mixed modes -> per-channel pulses match an independent reference model over 10k random cycles.
